// File: rtl/mire_writer_if.sv
// Wishbone master bus bundle used by mire_writer.
//   adr     : byte address of the current pixel word
//   dat_ms  : pixel word, master to slave
//   cyc/stb : bus tenure and strobe
//   we      : write enable (equal to cyc)
//   sel     : byte lanes (all four)
//   cti/bte : cycle type / burst type (classic cycles)
//   ack     : slave acknowledge
interface mire_writer_if;
  logic [31:0] adr;
  logic [31:0] dat_ms;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [3:0]  sel;
  logic [2:0]  cti;
  logic [1:0]  bte;
  logic        ack;

  modport master (
    output adr, dat_ms, cyc, stb, we, sel, cti, bte,
    input  ack
  );

  modport slave (
    input  adr, dat_ms, cyc, stb, we, sel, cti, bte,
    output ack
  );
endinterface

// File: rtl/mire_writer.sv
// mire_writer: writes a test-pattern frame (grid + colour ramp) into SDRAM
// over a classic Wishbone master. Words are written in tenures of at most
// BURST words, separated by GAP idle cycles so another master (the VGA
// reader) can reach the memory.
//
// Ports:
//   wshb_clk   : clock for the block and the bus
//   wshb_rst_n : asynchronous active-low reset
//   start      : one-cycle pulse, begins a frame from IDLE or DONE
//   loop       : sampled at end of frame; 1 restarts at (0,0) after a gap
//   busy       : high while writing or in an inter-tenure gap
//   frame_cnt  : number of completed frames (wraps)
//   wb         : Wishbone master bundle (adr, dat_ms, cyc, stb, we, sel,
//                cti, bte, ack)
module mire_writer #(
  parameter int HDISP = 800,
  parameter int VDISP = 480,
  parameter int BURST = 64,
  parameter int GAP   = 64
) (
  input  logic            wshb_clk,
  input  logic            wshb_rst_n,
  input  logic            start,
  input  logic            loop,
  output logic            busy,
  output logic [15:0]     frame_cnt,
  mire_writer_if.master   wb
);

  localparam int XW = (HDISP > 1) ? $clog2(HDISP) : 1;
  localparam int YW = (VDISP > 1) ? $clog2(VDISP) : 1;
  localparam int BW = $clog2(BURST + 1);
  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_GAP   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t         state_q, state_d;
  logic [XW-1:0]  x_q, x_d;
  logic [YW-1:0]  y_q, y_d;
  logic [BW-1:0]  burst_q, burst_d;
  logic [GW-1:0]  gap_q, gap_d;
  logic [15:0]    frame_q, frame_d;
  logic [31:0]    adr_q;
  logic [31:0]    dat_q;
  logic           load;
  logic           eol;
  logic           eof;

  // Grid lines every 16 pixels are white; elsewhere the colour encodes the
  // pixel position and the low byte of the frame number.
  function automatic logic [31:0] pixel(input logic [XW-1:0] x,
                                        input logic [YW-1:0] y,
                                        input logic [7:0]    f);
    logic [7:0] x8;
    logic [7:0] y8;
    x8 = 8'(x);
    y8 = 8'(y);
    if (x8[3:0] == 4'd0 || y8[3:0] == 4'd0)
      pixel = 32'h00FF_FFFF;
    else
      pixel = {8'h00, x8, y8, f};
  endfunction

  // Full 32-bit arithmetic so the linear index is never truncated to the
  // counter widths.
  function automatic logic [31:0] byte_adr(input logic [XW-1:0] x,
                                           input logic [YW-1:0] y);
    logic [31:0] idx;
    idx = 32'(y) * 32'(HDISP) + 32'(x);
    byte_adr = idx << 2;
  endfunction

  assign eol = (x_q == XW'(HDISP - 1));
  assign eof = eol && (y_q == YW'(VDISP - 1));

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    burst_d = burst_q;
    gap_d   = gap_q;
    frame_d = frame_q;
    load    = 1'b0;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_WRITE;
          x_d     = '0;
          y_d     = '0;
          burst_d = '0;
          gap_d   = '0;
          load    = 1'b1;
        end
      end

      S_WRITE: begin
        // ack only matters here; outside WRITE cyc is low and ack is ignored.
        if (wb.ack) begin
          load = 1'b1;
          if (eof) begin
            x_d     = '0;
            y_d     = '0;
            frame_d = frame_q + 16'd1;
            burst_d = '0;
            gap_d   = '0;
            state_d = loop ? S_GAP : S_DONE;
          end else begin
            if (eol) begin
              x_d = '0;
              y_d = y_q + 1'b1;
            end else begin
              x_d = x_q + 1'b1;
            end
            if (burst_q == BW'(BURST - 1)) begin
              burst_d = '0;
              gap_d   = '0;
              state_d = S_GAP;
            end else begin
              burst_d = burst_q + 1'b1;
            end
          end
        end
      end

      S_GAP: begin
        if (gap_q == GW'(GAP - 1)) begin
          gap_d   = '0;
          state_d = S_WRITE;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // Address and data are loaded only when the pixel position changes, so
  // they stay stable across wait states and remain 0 until the first start.
  always_ff @(posedge wshb_clk or negedge wshb_rst_n) begin
    if (!wshb_rst_n) begin
      state_q <= S_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      burst_q <= '0;
      gap_q   <= '0;
      frame_q <= '0;
      adr_q   <= '0;
      dat_q   <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      burst_q <= burst_d;
      gap_q   <= gap_d;
      frame_q <= frame_d;
      if (load) begin
        adr_q <= byte_adr(x_d, y_d);
        dat_q <= pixel(x_d, y_d, frame_d[7:0]);
      end
    end
  end

  // Bus controls decode straight from the state register, so an async
  // reset drops cyc immediately and the final ack edge ends the tenure.
  assign wb.cyc    = (state_q == S_WRITE);
  assign wb.stb    = (state_q == S_WRITE);
  assign wb.we     = (state_q == S_WRITE);
  assign wb.sel    = 4'b1111;
  assign wb.cti    = 3'b000;
  assign wb.bte    = 2'b00;
  assign wb.adr    = adr_q;
  assign wb.dat_ms = dat_q;

  assign busy      = (state_q == S_WRITE) || (state_q == S_GAP);
  assign frame_cnt = frame_q;

endmodule

// File: tb/tb_mire_writer.sv
`timescale 1ns/1ps
module tb_mire_writer;
  localparam int H = 4;
  localparam int V = 2;
  localparam int B = 3;
  localparam int G = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        loop = 1'b0;
  logic        busy;
  logic [15:0] frame_cnt;

  mire_writer_if bus();

  mire_writer #(.HDISP(H), .VDISP(V), .BURST(B), .GAP(G)) dut (
    .wshb_clk   (clk),
    .wshb_rst_n (rst_n),
    .start      (start),
    .loop       (loop),
    .busy       (busy),
    .frame_cnt  (frame_cnt),
    .wb         (bus.master)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h, want %08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_pix(input int x, input int y, input int f);
    if ((x % 16) == 0 || (y % 16) == 0) return 32'h00FF_FFFF;
    return 32'(((x & 255) << 16) | ((y & 255) << 8) | (f & 255));
  endfunction

  // ---------------- behavioural model + compare process ----------------
  int          m_n = 0;
  int          m_frame = 0;
  bit          m_active = 0;
  int          m_gap_left = 0;
  int          m_words = 0;
  bit          held_v = 0;
  logic [31:0] held_adr, held_dat;
  bit          rec = 0;
  logic [31:0] acc_q[$];
  int          mx, my;
  bit          m_eof;

  always @(negedge clk) begin
    if (!rst_n) begin
      m_n = 0; m_frame = 0; m_active = 0; m_gap_left = 0; m_words = 0; held_v = 0;
    end else begin
      check("busy", {31'd0, busy}, {31'd0, m_active});
      check("frame_cnt", {16'd0, frame_cnt}, 32'(m_frame & 32'hFFFF));
      check("ctrl", {23'd0, bus.stb, bus.we, bus.sel, bus.cti, bus.bte},
            {23'd0, bus.cyc, bus.cyc, 4'hF, 3'd0, 2'd0});
      check("cyc", {31'd0, bus.cyc}, {31'd0, (m_active && m_gap_left == 0)});
      if (held_v && bus.cyc && bus.stb) begin
        check("hold_adr", bus.adr, held_adr);
        check("hold_dat", bus.dat_ms, held_dat);
      end
      held_v   = bus.cyc && bus.stb && !bus.ack;
      held_adr = bus.adr;
      held_dat = bus.dat_ms;

      if (m_gap_left > 0) m_gap_left--;
      if (start && !m_active) begin
        m_active = 1; m_n = 0; m_words = 0; m_gap_left = 0;
      end else if (bus.cyc && bus.stb && bus.ack) begin
        mx = m_n % H;
        my = m_n / H;
        check("adr", bus.adr, 32'(4 * m_n));
        check("dat", bus.dat_ms, exp_pix(mx, my, m_frame));
        if (m_frame == 0 && m_n == 0) check("pix00", bus.dat_ms, 32'h00FF_FFFF);
        if (m_frame == 0 && m_n == 5) check("pix11", bus.dat_ms, 32'h0001_0100);
        if (rec) acc_q.push_back(bus.adr);
        m_n++;
        m_words++;
        m_eof = (m_n == H * V);
        if (m_eof) begin
          m_n = 0;
          m_frame++;
          if (!loop) m_active = 0;
        end
        if (m_eof || m_words == B) begin
          m_words = 0;
          if (m_active) m_gap_left = G;
        end
      end
    end
  end

  // ---------------- slave ack driver ----------------
  int ack_delay = 0;
  int ack_w = 0;
  initial begin
    bus.ack = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (ack_delay == 0) begin
        bus.ack = 1'b1;
        ack_w = 0;
      end else if (bus.ack) begin
        bus.ack = 1'b0;
        ack_w = 0;
      end else if (bus.cyc && bus.stb) begin
        if (ack_w == ack_delay) bus.ack = 1'b1;
        else ack_w++;
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk); #3 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (!busy) break;
    end
    check("idle_wait", {31'd0, busy}, 32'd0);
  endtask

  task automatic check_seq(input string tag, input int count);
    logic [31:0] exp_adr [8];
    exp_adr = '{32'd0, 32'd4, 32'd8, 32'd12, 32'd16, 32'd20, 32'd24, 32'd28};
    check({tag, "_count"}, 32'(acc_q.size()), 32'(count));
    for (int i = 0; i < 8; i++)
      check({tag, "_adr"}, (i < acc_q.size()) ? acc_q[i] : 32'hDEAD_BEEF, exp_adr[i]);
  endtask

  // Frame with ack tied high; optional start pulse injected in the first gap.
  task automatic run_basic(input bit inject, input string tag);
    logic [12:0] tr;
    tr = '0;
    acc_q.delete();
    rec = 1;
    pulse_start();
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      tr = {tr[11:0], bus.cyc};
      if (inject && i == 3) #2 start = 1'b1;
      if (inject && i == 4) #2 start = 1'b0;
    end
    rec = 0;
    check({tag, "_cyc_trace"}, {19'd0, tr}, {19'd0, 13'b1110011100110});
    check_seq(tag, 8);
    check({tag, "_busy_done"}, {31'd0, busy}, 32'd0);
    check({tag, "_frame"}, {16'd0, frame_cnt}, 32'd1);
  endtask

  initial begin
    // Reset state, with ack held high throughout.
    repeat (3) @(negedge clk);
    check("rst_cyc",   {31'd0, bus.cyc}, 32'd0);
    check("rst_stb",   {31'd0, bus.stb}, 32'd0);
    check("rst_we",    {31'd0, bus.we},  32'd0);
    check("rst_busy",  {31'd0, busy},    32'd0);
    check("rst_adr",   bus.adr,          32'd0);
    check("rst_dat",   bus.dat_ms,       32'd0);
    check("rst_frame", {16'd0, frame_cnt}, 32'd0);
    @(posedge clk); #3 rst_n = 1'b1;
    repeat (3) @(posedge clk);

    run_basic(1'b0, "basic");

    do_reset();
    run_basic(1'b1, "start_in_gap");

    // Every word acked after three wait states.
    ack_delay = 3;
    acc_q.delete();
    rec = 1;
    pulse_start();
    wait_idle(400);
    rec = 0;
    ack_delay = 0;
    check_seq("delayed", 8);
    check("delayed_frame", {16'd0, frame_cnt}, 32'd2);
    repeat (3) @(posedge clk);

    // Looping: two frames back to back, loop released during the second.
    loop = 1'b1;
    acc_q.delete();
    rec = 1;
    pulse_start();
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (frame_cnt == 16'd3) break;
    end
    check("loop_frame1", {16'd0, frame_cnt}, 32'd3);
    #1 loop = 1'b0;
    wait_idle(100);
    rec = 0;
    check("loop_frame2", {16'd0, frame_cnt}, 32'd4);
    check("loop_count", 32'(acc_q.size()), 32'd16);
    check("loop_last", (acc_q.size() > 7) ? acc_q[7] : 32'hDEAD_BEEF, 32'd28);
    check("loop_wrap", (acc_q.size() > 8) ? acc_q[8] : 32'hDEAD_BEEF, 32'd0);

    // Reset pulse in the middle of a tenure.
    pulse_start();
    @(negedge clk);
    @(posedge clk); #3 rst_n = 1'b0;
    #1;
    check("midrst_cyc",   {31'd0, bus.cyc}, 32'd0);
    check("midrst_stb",   {31'd0, bus.stb}, 32'd0);
    check("midrst_busy",  {31'd0, busy},    32'd0);
    check("midrst_adr",   bus.adr,          32'd0);
    check("midrst_frame", {16'd0, frame_cnt}, 32'd0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    repeat (8) @(negedge clk);
    check("post_rst_cyc",  {31'd0, bus.cyc}, 32'd0);
    check("post_rst_busy", {31'd0, busy},    32'd0);
    acc_q.delete();
    rec = 1;
    pulse_start();
    wait_idle(100);
    rec = 0;
    check_seq("after_rst", 8);
    check("after_rst_frame", {16'd0, frame_cnt}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
